vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 135 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA timing generator: free-running h/v counters, sync/blank/fetch decode, and a
// one-entry CPU write buffer that posts video-RAM writes only while the display is off the RAM.
module vga_timing_gen #(
    parameter int         H_SYNC     = 96,
    parameter int         H_BACK     = 48,
    parameter int         H_ACTIVE   = 640,
    parameter int         H_FRONT    = 16,
    parameter int         V_ACTIVE   = 480,
    parameter int         V_FRONT    = 10,
    parameter int         V_SYNC     = 2,
    parameter int         V_BACK     = 33,
    parameter int         FETCH_LEAD = 8,
    parameter logic       HSYNC_POL  = 1'b1,
    parameter logic       VSYNC_POL  = 1'b1,
    parameter logic [2:0] WIN_BASE   = 3'b111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_d,
    input  logic        cpu_we,
    output logic        cpu_rdy,
    output logic [9:0]  hx,
    output logic [9:0]  vy,
    output logic        hsync,
    output logic        vsync,
    output logic        n_pixel_ena,
    output logic        fetch_busy,
    output logic        ccol_rst,
    output logic        frame_start,
    output logic [11:0] ram_a,
    output logic [7:0]  ram_d,
    output logic        text_we,
    output logic        color_we
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int FS      = H_SYNC + H_BACK - FETCH_LEAD;

    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [10:0] HS_END    = 11'(H_SYNC);
    localparam logic [10:0] PIX_START = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] PIX_END   = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0] FET_START = 11'(FS);
    localparam logic [10:0] FET_END   = 11'(FS + H_ACTIVE);
    localparam logic [10:0] CCOL_POS  = 11'(FS - 1);
    localparam logic [10:0] V_VIS_END = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FRONT + V_SYNC);

    typedef enum logic {EMPTY, FULL} buf_state_t;

    buf_state_t  state_q, state_d;
    logic        capture, drain;
    logic [12:0] buf_addr;
    logic [7:0]  buf_data;
    logic [10:0] hx_w, vy_w;
    logic        line_visible;

    always_ff @(posedge clk) begin
        if (rst) begin
            hx <= '0;
            vy <= '0;
        end else if (hx == H_LAST) begin
            hx <= '0;
            vy <= (vy == V_LAST) ? 10'd0 : vy + 10'd1;
        end else begin
            hx <= hx + 10'd1;
        end
    end

    // One bit wider than the counters so bounds equal to 1024 still compare correctly.
    always_comb begin
        hx_w         = {1'b0, hx};
        vy_w         = {1'b0, vy};
        line_visible = (vy_w < V_VIS_END);
        hsync        = (hx_w < HS_END) ? HSYNC_POL : ~HSYNC_POL;
        vsync        = (vy_w >= VS_START && vy_w < VS_END) ? VSYNC_POL : ~VSYNC_POL;
        n_pixel_ena  = ~(line_visible && hx_w >= PIX_START && hx_w < PIX_END);
        fetch_busy   = line_visible && hx_w >= FET_START && hx_w < FET_END;
        ccol_rst     = (hx_w == CCOL_POS);
        frame_start  = (hx == 10'd0) && (vy == 10'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Accept only when empty; drain only when the display has released the RAM.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        drain   = 1'b0;
        case (state_q)
            EMPTY: begin
                if (cpu_we && cpu_a[15:13] == WIN_BASE) begin
                    capture = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (!fetch_busy) begin
                    drain   = 1'b1;
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_addr <= '0;
            buf_data <= '0;
        end else if (capture) begin
            buf_addr <= cpu_a[12:0];
            buf_data <= cpu_d;
        end
    end

    always_comb begin
        cpu_rdy  = (state_q == EMPTY);
        ram_a    = buf_addr[11:0];
        ram_d    = buf_data;
        text_we  = drain && !buf_addr[12];
        color_we = drain && buf_addr[12];
    end

endmodule
